// File: rtl/ghost_wall_arbiter_if.sv
// Query/response bundle between the four ghost controllers and the wall-lookup server.
// Ghost i owns slice i of req_x/req_y; gnt is one-hot and rsp_id names the ghost being answered.
interface ghost_wall_arbiter_if #(
    parameter int XW = 10,
    parameter int YW = 9
);
    logic [3:0]      req;
    logic [4*XW-1:0] req_x;
    logic [4*YW-1:0] req_y;
    logic [3:0]      gnt;
    logic            rsp_valid;
    logic [1:0]      rsp_id;
    logic            rsp_wall;

    modport master (
        output req, req_x, req_y,
        input  gnt, rsp_valid, rsp_id, rsp_wall
    );

    modport slave (
        input  req, req_x, req_y,
        output gnt, rsp_valid, rsp_id, rsp_wall
    );
endinterface

// File: rtl/ghost_wall_arbiter.sv
// Round-robin wall-lookup server for four ghosts plus the shared movement step_tick.
// Optional macro GHOST_STEP_GATE_EN holds a step_tick that lands while a query is in flight.
module ghost_wall_arbiter #(
    parameter int TILE         = 20,
    parameter int STEP_DIV     = 12_500_000,
    parameter int WIDTH        = 640,
    parameter int HEIGHT       = 480,
    parameter int TILE_COL_NUM = 32,
    parameter int TILE_ROW_NUM = 24
) (
    input  logic                                 clk,
    input  logic                                 reset,
    ghost_wall_arbiter_if.slave                  bus,
    input  logic [TILE_ROW_NUM*TILE_COL_NUM-1:0] tilemap_walls,
    output logic                                 busy,
    output logic                                 step_tick
);
    localparam int XW    = $clog2(WIDTH);
    localparam int YW    = $clog2(HEIGHT);
    localparam int NBITS = TILE_ROW_NUM * TILE_COL_NUM;
    localparam int IW    = $clog2(NBITS);
    localparam int SW    = $clog2(STEP_DIV);

    typedef enum logic [2:0] {IDLE, DIVX, DIVY, LOOKUP, RESP} state_t;

    state_t          r_state;
    logic [XW-1:0]   r_x_rem;
    logic [YW-1:0]   r_y_rem;
    logic [5:0]      r_col;
    logic [4:0]      r_row;
    logic [1:0]      r_ptr;
    logic [3:0]      r_gnt;
    logic            r_rsp_valid;
    logic [1:0]      r_rsp_id;
    logic            r_rsp_wall;
    logic            r_busy;
    logic [SW-1:0]   r_step_cnt;
    logic            r_step_tick;

    state_t          w_state_nxt;
    logic [XW-1:0]   w_x_nxt;
    logic [YW-1:0]   w_y_nxt;
    logic [5:0]      w_col_nxt;
    logic [4:0]      w_row_nxt;
    logic [1:0]      w_ptr_nxt;
    logic [3:0]      w_gnt_nxt;
    logic            w_rsp_valid_nxt;
    logic [1:0]      w_rsp_id_nxt;
    logic            w_rsp_wall_nxt;
    logic [1:0]      w_pick;
    logic [1:0]      w_cand;
    logic [IW-1:0]   w_idx;
    logic            w_off_map;
    logic            w_wrap_next;
    logic            w_tick_nxt;

    // Scan from ptr+4 down to ptr+1 so the nearest requester after ptr is written last and wins.
    always_comb begin
        w_pick = r_ptr;
        w_cand = r_ptr;
        for (int i = 4; i >= 1; i--) begin
            w_cand = r_ptr + 2'(i);
            if (bus.req[w_cand]) w_pick = w_cand;
        end
    end

    assign w_idx     = IW'(r_row) * IW'(TILE_COL_NUM) + IW'(r_col);
    assign w_off_map = (r_col >= 6'(TILE_COL_NUM)) || (r_row >= 5'(TILE_ROW_NUM));

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        w_state_nxt     = r_state;
        w_x_nxt         = r_x_rem;
        w_y_nxt         = r_y_rem;
        w_col_nxt       = r_col;
        w_row_nxt       = r_row;
        w_ptr_nxt       = r_ptr;
        w_gnt_nxt       = 4'b0000;
        w_rsp_valid_nxt = 1'b0;
        w_rsp_id_nxt    = r_rsp_id;
        w_rsp_wall_nxt  = r_rsp_wall;
        case (r_state)
            // RESP arbitrates like IDLE so back-to-back queries cost col+row+4 cycles each.
            IDLE, RESP: begin
                w_state_nxt = IDLE;
                if (|bus.req) begin
                    w_x_nxt          = bus.req_x[w_pick*XW +: XW];
                    w_y_nxt          = bus.req_y[w_pick*YW +: YW];
                    w_col_nxt        = '0;
                    w_row_nxt        = '0;
                    w_ptr_nxt        = w_pick;
                    w_rsp_id_nxt     = w_pick;
                    w_gnt_nxt[w_pick] = 1'b1;
                    w_state_nxt      = DIVX;
                end
            end
            DIVX: begin
                if (r_x_rem >= XW'(TILE)) begin
                    w_x_nxt   = r_x_rem - XW'(TILE);
                    w_col_nxt = r_col + 6'd1;
                end else begin
                    w_state_nxt = DIVY;
                end
            end
            DIVY: begin
                if (r_y_rem >= YW'(TILE)) begin
                    w_y_nxt   = r_y_rem - YW'(TILE);
                    w_row_nxt = r_row + 5'd1;
                end else begin
                    w_state_nxt = LOOKUP;
                end
            end
            LOOKUP: begin
                w_rsp_wall_nxt  = w_off_map ? 1'b1 : tilemap_walls[w_idx];
                w_rsp_valid_nxt = 1'b1;
                w_state_nxt     = RESP;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // The counter will read STEP_DIV-1 next cycle; registering this keeps step_tick glitch-free.
    assign w_wrap_next = (r_step_cnt == SW'(STEP_DIV - 2));

`ifdef GHOST_STEP_GATE_EN
    logic r_tick_pend;
    logic w_busy_nxt;
    logic w_pend_nxt;

    assign w_busy_nxt = (w_state_nxt != IDLE);
    assign w_tick_nxt = (w_wrap_next || r_tick_pend) && !w_busy_nxt;
    assign w_pend_nxt = (w_wrap_next || r_tick_pend) && w_busy_nxt;

    always_ff @(posedge clk) begin
        if (reset) r_tick_pend <= 1'b0;
        else       r_tick_pend <= w_pend_nxt;
    end
`else
    assign w_tick_nxt = w_wrap_next;
`endif

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_x_rem     <= '0;
            r_y_rem     <= '0;
            r_col       <= '0;
            r_row       <= '0;
            r_ptr       <= 2'd3;
            r_gnt       <= 4'b0000;
            r_rsp_valid <= 1'b0;
            r_rsp_id    <= 2'd0;
            r_rsp_wall  <= 1'b0;
            r_busy      <= 1'b0;
            r_step_cnt  <= '0;
            r_step_tick <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_x_rem     <= w_x_nxt;
            r_y_rem     <= w_y_nxt;
            r_col       <= w_col_nxt;
            r_row       <= w_row_nxt;
            r_ptr       <= w_ptr_nxt;
            r_gnt       <= w_gnt_nxt;
            r_rsp_valid <= w_rsp_valid_nxt;
            r_rsp_id    <= w_rsp_id_nxt;
            r_rsp_wall  <= w_rsp_wall_nxt;
            r_busy      <= (w_state_nxt != IDLE);
            r_step_cnt  <= (r_step_cnt == SW'(STEP_DIV - 1)) ? '0 : r_step_cnt + SW'(1);
            r_step_tick <= w_tick_nxt;
        end
    end

    assign bus.gnt       = r_gnt;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_id    = r_rsp_id;
    assign bus.rsp_wall  = r_rsp_wall;
    assign busy          = r_busy;
    assign step_tick     = r_step_tick;
endmodule

// File: doc/ghost_wall_arbiter.md
# ghost_wall_arbiter

Shared wall-lookup server and movement-step scheduler for the four ghost controllers. Each ghost asks "is tile (x,y) a wall?" before committing a move. This block arbitrates those queries round-robin onto one lookup datapath: it converts pixel coordinates to a tile index and samples `tilemap_walls`. It also generates the periodic `step_tick` that paces all ghost controllers.

## Interface
- `TILE`, 20: tile edge in pixels; coordinates are divided by this value.
- `STEP_DIV`, 12_500_000: clock cycles per `step_tick`; minimum 2.
- `clk`  in  1  system clock.
- `reset`  in  1  synchronous, active-high reset.
- `req`  in  4  query request per ghost; bit i is ghost i.
- `req_x`  in  4*$clog2(`WIDTH)  packed x coordinates; ghost i occupies slice i.
- `req_y`  in  4*$clog2(`HEIGHT)  packed y coordinates; ghost i occupies slice i.
- `tilemap_walls`  in  `tile_row_num*`tile_col_num  wall bitmap; bit `row*`tile_col_num+col` = 1 means wall.
- `gnt`  out  4  one-hot grant, 1-cycle pulse.
- `rsp_valid`  out  1  lookup result valid, 1-cycle pulse.
- `rsp_id`  out  2  index of the ghost being answered.
- `rsp_wall`  out  1  lookup result; 1 = wall or off-map.
- `busy`  out  1  high whenever the state is not IDLE.
- `step_tick`  out  1  1-cycle movement strobe.

## Operation
- FSM states: IDLE, DIVX, DIVY, LOOKUP, RESP.
- **IDLE**
  - If `req` is nonzero, pick the first set bit starting at `ptr+1` (mod 4).
  - Latch that ghost's x and y into `x_rem`/`y_rem`; clear `col` and `row`.
  - Pulse `gnt` for that ghost, set `ptr` to it, go to DIVX.
  - `req` bits are ignored outside IDLE. A requester drops `req` after `gnt`; a still-held `req` is re-arbitrated on the next IDLE.
- **DIVX**
  - While `x_rem >= TILE`: `x_rem -= TILE`, `col += 1`, one subtraction per cycle.
  - When `x_rem < TILE`, go to DIVY. DIVX lasts col+1 cycles.
- **DIVY**: same procedure on `y_rem`/`row`; lasts row+1 cycles.
- **LOOKUP**
  - If `col >= `tile_col_num` or `row >= `tile_row_num`, wall = 1.
  - Otherwise wall = `tilemap_walls[row*`tile_col_num+col]`.
  - Result is registered.
- **RESP**: `rsp_valid`=1 with `rsp_id` and `rsp_wall` driven; return to IDLE.
- Widths:
  - `col` is 6 bits; `row` is 5 bits.
  - Subtractions never underflow, because each is guarded by the compare.
  - The tile index is computed at full bitmap-index width.
- Round-robin pointer `ptr` resets to 3, so ghost 0 wins the first arbitration.
- Step counter:
  - Counts 0..STEP_DIV-1 and wraps.
  - `step_tick`=1 in the cycle the counter equals STEP_DIV-1.
  - Runs independently of the FSM unless gated (see Configuration).
- Reset:
  - Values: state IDLE; `gnt`=0, `rsp_valid`=0, `rsp_id`=0, `rsp_wall`=0, `busy`=0, `step_tick`=0; step counter 0; `ptr`=3.
  - Reset mid-query abandons the query; no `rsp_valid` is produced.

## Timing
- Arbitration edge E0: IDLE samples a nonzero `req`.
- `gnt` is high during cycle 1 after E0; `busy` is high from cycle 1 through the RESP cycle.
- `rsp_valid` is high in cycle col+row+4 after E0. Example: (280,240) gives col 14, row 12, so cycle 30.
- A new arbitration can occur on the edge ending the RESP cycle; the next `gnt` appears one cycle after that.
- Throughput: one query per col+row+4 cycles. Worst case on-map: (620,460) gives 31+23+4 = 58 cycles.
- Coordinates are sampled only at E0; later changes to `req_x`/`req_y` have no effect.
- `tilemap_walls` is sampled in the LOOKUP cycle.
- All outputs are registered; there are no combinational paths from input to output.

## Configuration
- `GHOST_STEP_GATE_EN` defined:
  - A `step_tick` that would fire while `busy`=1 is held pending.
  - It fires in the first cycle `busy` is 0, i.e. the cycle after RESP.
  - The step counter keeps counting; at most one tick is pending at a time, and further ticks while one is pending are dropped.
  - This guarantees ghosts never step while holding an unanswered query.
- Not defined: `step_tick` is strictly periodic, and the FSM has no effect on it.

## Test plan
- Assert `reset` for 2 cycles, then release with `req`=0 and STEP_DIV=4 → all outputs 0; `step_tick` pulses at cycles 4, 8, 12 after release.
- `req`=0010, ghost 1 at (280,240), bitmap bit 398 set → `gnt`=0010 at cycle 1; `rsp_valid`=1, `rsp_id`=1, `rsp_wall`=1 at cycle 30. Repeat with bit 398 clear → `rsp_wall`=0.
- `req`=1111 held, all ghosts at (0,0) → grants in order 0, 1, 2, 3, 0; each response arrives 4 cycles after its arbitration edge; `rsp_id` follows the grant order.
- Ghost 2 at (640,0) → `col`=32 is off-map; `rsp_wall`=1 at cycle 36 regardless of the bitmap.
- Ghost 0 at (620,460); assert `reset` in cycle 10 → `busy`=0 the next cycle; no `rsp_valid`; a fresh `req`=0001 then gets `gnt`=0001.
- With `GHOST_STEP_GATE_EN` and STEP_DIV=4, start a 58-cycle query at a counter wrap → no `step_tick` while `busy`; exactly one `step_tick` in the cycle after RESP; periodic ticks resume afterward.
